// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: 16x oversampling UART receiver with runtime frame format, majority-vote
// sampling, parity/frame/overrun/break flags and a valid/ready output port.
module uart_rx_cfg #(
    parameter int DIV_W  = 16,
    parameter int SYNC_N = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_dbits,
    input  logic [1:0]       cfg_par,
    input  logic             cfg_stop2,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             err_parity,
    output logic             err_frame,
    output logic             err_overrun,
    output logic             brk
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BRKWAIT} state_t;
    state_t            state, state_nx;
    logic [SYNC_N-1:0] sync;
    logic              din_s, din_q;
    logic [DIV_W-1:0]  div_cnt, div_l;
    logic [3:0]        os_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        sh;
    logic [1:0]        dbits_l;
    logic              s7, s8, run, tick, samp, vote, start_det, last_bit, is_brk, par_err;
    logic              par_en, par_odd, stop2_l, par_bit, stop_err, stop1_zero, commit, accept;

    assign din_s     = sync[SYNC_N-1];
    assign start_det = state == IDLE && din_q && !din_s;
    assign run       = state == START || state == DATA || state == PARITY || state == STOP1 || state == STOP2;
    assign tick      = run && div_cnt == div_l;
    assign samp      = tick && os_cnt == 4'd9;
    assign vote      = (s7 & s8) | (s7 & din_s) | (s8 & din_s);
    assign last_bit  = bit_cnt == {1'b1, dbits_l};
    assign par_err   = par_en && ((^sh ^ par_bit) != par_odd);
    assign is_brk    = sh == 8'd0 && !(par_en && par_bit) && stop1_zero;
    assign commit    = state == DONE;
    assign accept    = rx_valid && rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start_det ? START : IDLE;
            START:   state_nx = samp ? (vote ? IDLE : DATA) : START;
            DATA:    state_nx = samp && last_bit ? (par_en ? PARITY : STOP1) : DATA;
            PARITY:  state_nx = samp ? STOP1 : PARITY;
            STOP1:   state_nx = samp ? (stop2_l ? STOP2 : DONE) : STOP1;
            STOP2:   state_nx = samp ? DONE : STOP2;
            DONE:    state_nx = is_brk ? BRKWAIT : IDLE;
            BRKWAIT: state_nx = din_s ? IDLE : BRKWAIT;
            default: state_nx = IDLE;
        endcase
    end

    // Frame timing restarts from the detected start edge; format is frozen for the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync       <= '1;
            din_q      <= 1'b1;
            div_cnt    <= '0;
            div_l      <= '0;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            dbits_l    <= '0;
            s7         <= 1'b1;
            s8         <= 1'b1;
            par_en     <= 1'b0;
            par_odd    <= 1'b0;
            stop2_l    <= 1'b0;
            par_bit    <= 1'b0;
            stop_err   <= 1'b0;
            stop1_zero <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_N-2:0], din};
            din_q <= din_s;
            if (start_det) begin
                div_cnt    <= '0;
                os_cnt     <= '0;
                bit_cnt    <= '0;
                sh         <= '0;
                div_l      <= cfg_div;
                dbits_l    <= cfg_dbits;
                par_en     <= cfg_par[0] ^ cfg_par[1];
                par_odd    <= cfg_par == 2'b10;
                stop2_l    <= cfg_stop2;
                par_bit    <= 1'b0;
                stop_err   <= 1'b0;
                stop1_zero <= 1'b0;
            end else if (run) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) os_cnt <= os_cnt + 1'b1;
                if (tick && os_cnt == 4'd7) s7 <= din_s;
                if (tick && os_cnt == 4'd8) s8 <= din_s;
                if (samp && state == DATA) begin
                    sh[bit_cnt] <= vote;
                    bit_cnt     <= bit_cnt + 1'b1;
                end
                if (samp && state == PARITY) par_bit <= vote;
                if (samp && state == STOP1) stop1_zero <= !vote;
                if (samp && (state == STOP1 || state == STOP2) && !vote) stop_err <= 1'b1;
            end
        end
    end

    // A commit that collides with an unaccepted word only raises overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
            brk         <= 1'b0;
        end else if (commit && rx_valid && !rx_ready) begin
            err_overrun <= 1'b1;
        end else if (commit) begin
            rx_data     <= sh;
            rx_valid    <= 1'b1;
            err_parity  <= par_err && !is_brk;
            err_frame   <= stop_err;
            err_overrun <= 1'b0;
            brk         <= is_brk;
        end else if (accept) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
            brk         <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: table-driven frame vectors plus hand-written sequences for glitch,
// break, overrun and mid-frame reset.
module tb_uart_rx_cfg;
    localparam int DIV = 3;
    localparam int BT  = 16 * (DIV + 1);

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
        logic       bk;
    } word_t;

    typedef struct {
        logic [11:0] bits;
        int          n;
        logic [1:0]  dbits;
        logic [1:0]  par;
        logic        stop2;
        word_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b1;
    logic [15:0] cfg_div = 16'(DIV);
    logic [1:0]  cfg_dbits = 2'b11;
    logic [1:0]  cfg_par = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        err_parity, err_frame, err_overrun, brk;

    int    checks = 0;
    int    failures = 0;
    word_t q[$];
    vec_t  vecs[7];

    uart_rx_cfg #(.DIV_W(16), .SYNC_N(2)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .cfg_div(cfg_div), .cfg_dbits(cfg_dbits),
        .cfg_par(cfg_par), .cfg_stop2(cfg_stop2), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .err_parity(err_parity), .err_frame(err_frame),
        .err_overrun(err_overrun), .brk(brk)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && rx_valid && rx_ready) q.push_back({rx_data, err_parity, err_frame, err_overrun, brk});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(input string name, input word_t exp);
        word_t got;
        got = 'x;
        if (q.size() > 0) got = q.pop_front();
        check(name, 32'(got), 32'(exp));
    endtask

    task automatic send(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            din = bits[i];
            repeat (BT) @(negedge clk);
        end
        din = 1'b1;
    endtask

    task automatic idle(input int bits);
        repeat (bits * BT) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] dbits, input logic [1:0] par, input logic stop2);
        cfg_dbits = dbits;
        cfg_par   = par;
        cfg_stop2 = stop2;
    endtask

    initial begin
        vecs[0] = '{{2'b11, 1'b1, 8'hA5, 1'b0}, 10, 2'b11, 2'b00, 1'b0, {8'hA5, 4'b0000}};
        vecs[1] = '{{2'b11, 1'b1, 1'b1, 7'h35, 1'b0}, 10, 2'b10, 2'b01, 1'b0, {8'h35, 4'b1000}};
        vecs[2] = '{{1'b1, 1'b0, 1'b1, 8'h3C, 1'b0}, 11, 2'b11, 2'b00, 1'b1, {8'h3C, 4'b0100}};
        vecs[3] = '{{3'b111, 1'b1, 1'b0, 6'h2A, 1'b0}, 9, 2'b01, 2'b10, 1'b0, {8'h2A, 4'b0000}};
        vecs[4] = '{{5'b11111, 1'b1, 5'h1F, 1'b0}, 7, 2'b00, 2'b00, 1'b0, {8'h1F, 4'b0000}};
        vecs[5] = '{{1'b1, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, 2'b11, 2'b01, 1'b0, {8'h5A, 4'b0000}};
        vecs[6] = '{{2'b11, 1'b1, 8'hC3, 1'b0}, 10, 2'b11, 2'b11, 1'b0, {8'hC3, 4'b0000}};

        repeat (3) @(negedge clk);
        check("reset_outputs", {rx_valid, rx_data, err_parity, err_frame, err_overrun, brk}, 0);
        rst_n = 1'b1;
        idle(1);

        for (int i = 0; i < 7; i++) begin
            set_cfg(vecs[i].dbits, vecs[i].par, vecs[i].stop2);
            q.delete();
            send(vecs[i].bits, vecs[i].n);
            idle(2);
            check($sformatf("vec%0d_count", i), q.size(), 1);
            expect_word($sformatf("vec%0d_word", i), vecs[i].exp);
        end

        // 8N2 frame with second stop low, received as 8N1: clean word, then the low
        // second stop acts as a start bit whose data bits are the idle line (0xFF).
        set_cfg(2'b11, 2'b00, 1'b0);
        q.delete();
        send({1'b1, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
        idle(12);
        check("stop1cfg_count", q.size(), 2);
        expect_word("stop1cfg_word", {8'h3C, 4'b0000});
        expect_word("stop1cfg_tail", {8'hFF, 4'b0000});

        din = 1'b0;
        repeat (4 * (DIV + 1)) @(negedge clk);
        din = 1'b1;
        idle(2);
        check("glitch_none", q.size(), 0);
        send({2'b11, 1'b1, 8'h5A, 1'b0}, 10);
        idle(2);
        check("after_glitch_count", q.size(), 1);
        expect_word("after_glitch_word", {8'h5A, 4'b0000});

        din = 1'b0;
        idle(12);
        check("break_count", q.size(), 1);
        expect_word("break_word", {8'h00, 4'b0101});
        din = 1'b1;
        idle(3);
        check("break_no_more", q.size(), 0);

        rx_ready = 1'b0;
        send({2'b11, 1'b1, 8'h11, 1'b0}, 10);
        idle(1);
        send({2'b11, 1'b1, 8'h22, 1'b0}, 10);
        idle(2);
        check("ovr_held_valid", rx_valid, 1);
        check("ovr_held_data", rx_data, 8'h11);
        check("ovr_flag", {err_parity, err_frame, err_overrun, brk}, 4'b0010);
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_cleared", {rx_valid, rx_data, err_parity, err_frame, err_overrun, brk}, 0);
        expect_word("ovr_accepted", {8'h11, 4'b0010});
        idle(2);
        check("ovr_dropped", q.size(), 0);

        rx_ready = 1'b0;
        send({2'b11, 1'b1, 8'h77, 1'b0}, 10);
        idle(1);
        check("pre_reset_valid", rx_valid, 1);
        din = 1'b0;
        idle(1);
        din = 1'b1;
        repeat (4 * BT + BT / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_abort", {rx_valid, rx_data, err_parity, err_frame, err_overrun, brk}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_ready = 1'b1;
        idle(6);
        check("reset_no_partial", q.size(), 0);
        send({2'b11, 1'b1, 8'h81, 1'b0}, 10);
        idle(2);
        check("post_reset_count", q.size(), 1);
        expect_word("post_reset_word", {8'h81, 4'b0000});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
